// File: rtl/mpu_led_monitor.sv
// Debug display stage: captures a CH_N x 16-bit frame and shows one byte on LEDs, with a sticky I2C error flag and an error counter.
// Optional per-channel peak-magnitude registers are enabled by defining MPU_LED_PEAK_EN.
module mpu_led_monitor #(
    parameter int unsigned FPGA_CLK = 50_000_000,
    parameter int unsigned CH_N     = 3,
    parameter int unsigned DWELL_MS = 500,
    localparam int unsigned CHW     = (CH_N > 1) ? $clog2(CH_N) : 1
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               I_FL,
    input  logic [16*CH_N-1:0] I_DATA,
    input  logic               I_ACK,
    input  logic               I_ERR,
    input  logic               I_CLR,
    input  logic               I_FREEZE,
    input  logic               I_AUTO,
    input  logic [CHW-1:0]     I_CH,
    input  logic               I_BYTE,
    input  logic               I_PEAK,
    output logic [9:0]         O_LEDR,
    output logic [CHW-1:0]     O_CH,
    output logic               O_PHASE,
    output logic [7:0]         O_ERR_CNT,
    output logic               O_NEW
);

    localparam int unsigned DWELL_CYC = FPGA_CLK / 1000 * DWELL_MS;
    localparam int unsigned TW        = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

    typedef enum logic [1:0] {MANUAL, SCR_HI, SCR_LO} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic                phase_q, phase_d;
    logic [16*CH_N-1:0]  frame_q;
    logic                new_q;
    logic                ack_q;
    logic                err_sticky_q, err_sticky_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [7:0]          byte_q, byte_d;
    logic [CHW-1:0]      man_ch;
    logic [CHW-1:0]      ch_inc;
    logic                capture;
    logic [15:0]         word;

    assign capture = I_FL & ~I_FREEZE;

    always_comb begin
        man_ch = I_CH;
        if (32'(I_CH) >= CH_N) man_ch = CHW'(CH_N - 1);
        ch_inc = (ch_q == CHW'(CH_N - 1)) ? '0 : ch_q + CHW'(1);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ch_d    = ch_q;
        phase_d = phase_q;
        case (state_q)
            MANUAL: begin
                timer_d = '0;
                if (I_AUTO) begin
                    state_d = SCR_HI;
                    ch_d    = '0;
                    phase_d = 1'b0;
                end else begin
                    ch_d    = man_ch;
                    phase_d = I_BYTE;
                end
            end
            SCR_HI, SCR_LO: begin
                if (!I_AUTO) begin
                    state_d = MANUAL;
                    timer_d = '0;
                    ch_d    = man_ch;
                    phase_d = I_BYTE;
                end else if (timer_q == TW'(DWELL_CYC - 1)) begin
                    timer_d = '0;
                    if (state_q == SCR_HI) begin
                        state_d = SCR_LO;
                        phase_d = 1'b1;
                    end else begin
                        state_d = SCR_HI;
                        phase_d = 1'b0;
                        ch_d    = ch_inc;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = MANUAL;
                timer_d = '0;
            end
        endcase
    end

    // Set takes priority over clear so an error in the clearing cycle is never lost.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (I_ERR)      err_sticky_d = 1'b1;
        else if (I_CLR) err_sticky_d = 1'b0;
        if (I_CLR)                           err_cnt_d = I_ERR ? 8'd1 : 8'd0;
        else if (I_ERR && err_cnt_q != '1)   err_cnt_d = err_cnt_q + 8'd1;
    end

`ifdef MPU_LED_PEAK_EN
    logic [15:0] peak_q [CH_N];
    logic [15:0] peak_d [CH_N];

    always_comb begin
        logic [15:0] s;
        logic [15:0] mag;
        for (int unsigned c = 0; c < CH_N; c++) begin
            s   = I_DATA[16*c +: 16];
            mag = s;
            if (s[15]) mag = (s == 16'h8000) ? 16'h7FFF : (~s + 16'd1);
            peak_d[c] = I_CLR ? '0 : peak_q[c];
            if (capture && mag > peak_d[c]) peak_d[c] = mag;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int unsigned c = 0; c < CH_N; c++) peak_q[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < CH_N; c++) peak_q[c] <= peak_d[c];
        end
    end

    always_comb begin
        word = '0;
        for (int unsigned c = 0; c < CH_N; c++) begin
            if (ch_q == CHW'(c)) word = I_PEAK ? peak_q[c] : frame_q[16*c +: 16];
        end
    end
`else
    logic unused_peak;
    assign unused_peak = I_PEAK;

    always_comb begin
        word = '0;
        for (int unsigned c = 0; c < CH_N; c++) begin
            if (ch_q == CHW'(c)) word = frame_q[16*c +: 16];
        end
    end
`endif

    assign byte_d = phase_q ? word[7:0] : word[15:8];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= MANUAL;
            timer_q      <= '0;
            ch_q         <= '0;
            phase_q      <= 1'b0;
            frame_q      <= '0;
            new_q        <= 1'b0;
            ack_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            byte_q       <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ch_q         <= ch_d;
            phase_q      <= phase_d;
            if (capture) frame_q <= I_DATA;
            new_q        <= capture;
            ack_q        <= I_ACK;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            byte_q       <= byte_d;
        end
    end

    assign O_LEDR    = {err_sticky_q, ack_q, byte_q};
    assign O_CH      = ch_q;
    assign O_PHASE   = phase_q;
    assign O_ERR_CNT = err_cnt_q;
    assign O_NEW     = new_q;

endmodule
